// File: rtl/display_frame_mux_pkg.sv
//------------------------------------------------------------------------------
// Module   : display_pkg
// Brief    : Shared nibble codes, digit type and handshake states for display_frame_mux
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package display_pkg;

    localparam logic [3:0] BLANK_NIBBLE = 4'hA;
    localparam logic [3:0] NEG_NIBBLE   = 4'hF;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PEND = 1'b1
    } disp_state_e;

endpackage

`default_nettype wire

// File: rtl/display_frame_mux_zero_blank.sv
//------------------------------------------------------------------------------
// Module   : zero_blank
// Brief    : Replaces leading zero nibbles below the sign nibble with BLANK_NIBBLE
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module zero_blank
    import display_pkg::*;
#(
    parameter int DISP_DIGITS = 8
) (
    input  logic [4*DISP_DIGITS-1:0] i_raw_frame,
    input  logic                     i_blank_en,
    output logic [4*DISP_DIGITS-1:0] o_frame
);

    logic       w_lead;
    bcd_digit_t w_nib;

    // Pad nibbles are always zero, so they blank through the same leading-zero scan.
    // The sign nibble and the least-significant digit are excluded from the scan.
    always_comb begin
        o_frame = i_raw_frame;
        w_lead  = 1'b1;
        w_nib   = 4'h0;
        for (int i = DISP_DIGITS - 2; i >= 1; i--) begin
            w_nib = i_raw_frame[4*i +: 4];
            if (w_nib != 4'h0) begin
                w_lead = 1'b0;
            end else if (w_lead && i_blank_en) begin
                o_frame[4*i +: 4] = BLANK_NIBBLE;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/display_frame_mux.sv
//------------------------------------------------------------------------------
// Module   : display_frame_mux
// Brief    : Selects a sign-magnitude BCD source and hands a formatted frame to the display manager
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module display_frame_mux
    import display_pkg::*;
#(
    parameter int NUM_CH      = 3,
    parameter int SRC_DIGITS  = 6,
    parameter int DISP_DIGITS = 8,
    parameter int DWELL       = 50_000_000
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_CH*(4*SRC_DIGITS+1)-1:0]  src_data,
    input  logic [$clog2(NUM_CH)-1:0]           sel,
    input  logic                                auto_en,
    input  logic                                blank_en,
    input  logic                                frame_ack,
    output logic [4*DISP_DIGITS-1:0]            frame,
    output logic                                frame_valid,
    output logic [$clog2(NUM_CH)-1:0]           cur_ch
);

    localparam int c_SRC_W   = 4*SRC_DIGITS + 1;
    localparam int c_SEL_W   = $clog2(NUM_CH);
    localparam int c_CNT_W   = $clog2(DWELL);
    localparam int c_FRAME_W = 4*DISP_DIGITS;

    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DWELL - 1);
    localparam logic [c_SEL_W-1:0] c_CH_LAST  = c_SEL_W'(NUM_CH - 1);

    logic [c_SRC_W-1:0]   w_ch [NUM_CH];
    logic [c_SRC_W-1:0]   w_src;
    logic [c_FRAME_W-1:0] w_raw;
    logic [c_FRAME_W-1:0] w_cand;
    logic                 w_new;

    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_SEL_W-1:0]   r_cur_ch;
    logic [c_FRAME_W-1:0] r_frame;
    logic                 r_valid;
    logic                 r_force;
    logic                 r_armed;
    disp_state_e          r_state;

    generate
        for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
            assign w_ch[k] = src_data[k*c_SRC_W +: c_SRC_W];
        end
    endgenerate

    assign w_src = w_ch[r_cur_ch];

    always_comb begin
        w_raw = '0;
        w_raw[4*SRC_DIGITS-1:0]  = w_src[4*SRC_DIGITS-1:0];
        w_raw[c_FRAME_W-1 -: 4]  = w_src[c_SRC_W-1] ? NEG_NIBBLE : 4'h0;
    end

    zero_blank #(
        .DISP_DIGITS (DISP_DIGITS)
    ) u_zero_blank (
        .i_raw_frame (w_raw),
        .i_blank_en  (blank_en),
        .o_frame     (w_cand)
    );

    // Holding the counter at 0 outside auto mode makes entry into auto mode
    // start a full dwell period from the current channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt    <= '0;
            r_cur_ch <= '0;
        end else if (!auto_en) begin
            r_cnt <= '0;
            if (int'(sel) < NUM_CH) begin
                r_cur_ch <= sel;
            end
        end else if (r_cnt == c_CNT_LAST) begin
            r_cnt    <= '0;
            r_cur_ch <= (r_cur_ch == c_CH_LAST) ? '0 : r_cur_ch + 1'b1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign w_new = r_force | (w_cand != r_frame);

    // r_armed spends the first post-reset edge letting cur_ch settle, so the
    // first frame is presented on the second edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_frame <= '0;
            r_valid <= 1'b0;
            r_force <= 1'b1;
            r_armed <= 1'b0;
        end else begin
            r_armed <= 1'b1;
            if (r_armed) begin
                case (r_state)
                    IDLE: begin
                        if (w_new) begin
                            r_frame <= w_cand;
                            r_valid <= 1'b1;
                            r_force <= 1'b0;
                            r_state <= PEND;
                        end
                    end
                    PEND: begin
                        if (frame_ack) begin
                            if (w_new) begin
                                r_frame <= w_cand;
                                r_force <= 1'b0;
                            end else begin
                                r_valid <= 1'b0;
                                r_state <= IDLE;
                            end
                        end
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign frame       = r_frame;
    assign frame_valid = r_valid;
    assign cur_ch      = r_cur_ch;

endmodule

`default_nettype wire

// File: tb/tb_display_frame_mux.sv
//------------------------------------------------------------------------------
// Module   : tb_display_frame_mux
// Brief    : Randomised scoreboard bench for display_frame_mux with a behavioural model
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_display_frame_mux;

    localparam int NUM_CH      = 3;
    localparam int SRC_DIGITS  = 6;
    localparam int DISP_DIGITS = 8;
    localparam int DWELL       = 4;
    localparam int W           = 4*SRC_DIGITS + 1;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [NUM_CH*W-1:0]    src_data = '0;
    logic [1:0]             sel = 2'd0;
    logic                   auto_en = 1'b0;
    logic                   blank_en = 1'b0;
    logic                   frame_ack = 1'b0;
    logic [31:0]            frame;
    logic                   frame_valid;
    logic [1:0]             cur_ch;

    int n_checks = 0;
    int n_errors = 0;

    display_frame_mux #(
        .NUM_CH      (NUM_CH),
        .SRC_DIGITS  (SRC_DIGITS),
        .DISP_DIGITS (DISP_DIGITS),
        .DWELL       (DWELL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .src_data    (src_data),
        .sel         (sel),
        .auto_en     (auto_en),
        .blank_en    (blank_en),
        .frame_ack   (frame_ack),
        .frame       (frame),
        .frame_valid (frame_valid),
        .cur_ch      (cur_ch)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    // Reference formatting: sign nibble, digits, and blanking of every nibble
    // above the most significant nonzero digit (the units digit always kept).
    function automatic logic [31:0] fmt(logic [W-1:0] s, logic blank);
        logic [31:0] r;
        int msnz;
        r = '0;
        msnz = 0;
        for (int i = 0; i < SRC_DIGITS; i++) begin
            r[4*i +: 4] = s[4*i +: 4];
            if (s[4*i +: 4] != 4'h0) msnz = i;
        end
        r[31:28] = s[W-1] ? 4'hF : 4'h0;
        if (blank) begin
            for (int p = msnz + 1; p < DISP_DIGITS - 1; p++) r[4*p +: 4] = 4'hA;
        end
        return r;
    endfunction

    // Behavioural model and scoreboard producer
    logic [31:0] exp_q[$];
    int          m_ch, m_cnt;
    logic        m_armed, m_force, m_valid;
    logic [31:0] m_frame;
    logic [31:0] m_cand;

    always_comb m_cand = fmt(src_data[m_ch*W +: W], blank_en);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_ch    <= 0;
            m_cnt   <= 0;
            m_armed <= 1'b0;
            m_force <= 1'b1;
            m_valid <= 1'b0;
            m_frame <= '0;
            exp_q.delete();
        end else begin
            m_armed <= 1'b1;
            if (m_armed && (!m_valid || frame_ack)) begin
                if (m_force || m_cand != m_frame) begin
                    m_frame <= m_cand;
                    m_valid <= 1'b1;
                    m_force <= 1'b0;
                    exp_q.push_back(m_cand);
                end else begin
                    m_valid <= 1'b0;
                end
            end
            if (!auto_en) begin
                m_cnt <= 0;
                if (int'(sel) < NUM_CH) m_ch <= int'(sel);
            end else if (m_cnt == DWELL - 1) begin
                m_cnt <= 0;
                m_ch  <= (m_ch + 1) % NUM_CH;
            end else begin
                m_cnt <= m_cnt + 1;
            end
        end
    end

    // Monitor: a load is visible as frame_valid rising, or staying high after an ack
    initial begin
        logic        s_ack;
        logic        prev_valid;
        logic [31:0] last;
        logic [31:0] e;
        prev_valid = 1'b0;
        last = '0;
        forever begin
            @(posedge clk);
            s_ack = frame_ack;
            #1;
            if (!rst_n) begin
                chk("reset_frame", frame, 32'h0);
                chk("reset_valid", {31'd0, frame_valid}, 32'd0);
                chk("reset_cur_ch", {30'd0, cur_ch}, 32'd0);
                prev_valid = 1'b0;
                last = '0;
            end else begin
                if (frame_valid && (!prev_valid || s_ack)) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_load", frame, last);
                    end else begin
                        e = exp_q.pop_front();
                        chk("loaded_frame", frame, e);
                        last = e;
                    end
                end else begin
                    chk("held_frame", frame, last);
                end
                if (exp_q.size() != 0) begin
                    chk("missed_load", exp_q.size(), 0);
                    exp_q.delete();
                end
                chk("frame_valid", {31'd0, frame_valid}, {31'd0, m_valid});
                chk("cur_ch", {30'd0, cur_ch}, m_ch);
                prev_valid = frame_valid;
            end
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_ch(int k, logic sgn, logic [23:0] dig);
        src_data[k*W +: W] = {sgn, dig};
    endtask

    task automatic settle();
        @(negedge clk);
        frame_ack = 1'b1;
        repeat (3) @(negedge clk);
        frame_ack = 1'b0;
        @(negedge clk);
    endtask

    function automatic logic [23:0] rand_dig();
        logic [23:0] d;
        int lead;
        lead = $urandom_range(0, SRC_DIGITS);
        d = '0;
        for (int i = 0; i < SRC_DIGITS; i++) begin
            if (i < SRC_DIGITS - lead)
                d[4*i +: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                          : 4'($urandom_range(0, 9));
        end
        return d;
    endfunction

    int exp_seq[13] = '{0, 0, 0, 0, 1, 1, 1, 1, 2, 2, 2, 2, 0};

    initial begin
        set_ch(0, 1'b0, 24'h000123);
        cyc(2);
        chk("rst_frame", frame, 32'h0);
        chk("rst_valid", {31'd0, frame_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_edge_valid", {31'd0, frame_valid}, 32'd0);
        @(posedge clk); #1;
        chk("second_edge_valid", {31'd0, frame_valid}, 32'd1);
        chk("first_frame", frame, 32'h00000123);

        // Blanking and sign
        set_ch(1, 1'b1, 24'h000045);
        blank_en = 1'b1;
        sel = 2'd1;
        settle();
        chk("blank_neg", frame, 32'hFAAAAA45);
        set_ch(1, 1'b0, 24'h000000);
        settle();
        chk("blank_zero", frame, 32'h0AAAAAA0);

        // Handshake stall
        blank_en = 1'b0;
        sel = 2'd0;
        set_ch(0, 1'b0, 24'h000001);
        settle();
        chk("stall_base", frame, 32'h00000001);
        set_ch(0, 1'b0, 24'h000222);
        cyc(1);
        chk("stall_load", frame, 32'h00000222);
        set_ch(0, 1'b0, 24'h000333); cyc(1);
        set_ch(0, 1'b0, 24'h000444); cyc(1);
        set_ch(0, 1'b0, 24'h000555); cyc(1);
        chk("stall_frozen", frame, 32'h00000222);
        frame_ack = 1'b1; cyc(1); frame_ack = 1'b0;
        chk("stall_ack_frame", frame, 32'h00000555);
        chk("stall_ack_valid", {31'd0, frame_valid}, 32'd1);
        frame_ack = 1'b1; cyc(1); frame_ack = 1'b0;
        chk("stall_release_valid", {31'd0, frame_valid}, 32'd0);

        // Invalid select holds channel
        set_ch(1, 1'b1, 24'h999999);
        sel = 2'd3;
        cyc(3);
        chk("bad_sel_ch", {30'd0, cur_ch}, 32'd0);
        chk("bad_sel_valid", {31'd0, frame_valid}, 32'd0);
        sel = 2'd0;
        cyc(1);

        // Auto rotation
        auto_en = 1'b1;
        frame_ack = 1'b1;
        for (int k = 0; k < 13; k++) begin
            chk("auto_seq", {30'd0, cur_ch}, exp_seq[k]);
            cyc(1);
        end
        auto_en = 1'b0;
        frame_ack = 1'b0;

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 2) == 0)
                set_ch($urandom_range(0, NUM_CH - 1), 1'($urandom_range(0, 1)), rand_dig());
            if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) blank_en = ~blank_en;
            if ($urandom_range(0, 31) == 0) auto_en = ~auto_en;
            frame_ack = 1'($urandom_range(0, 1));
            cyc(1);
        end

        // Reset mid-PEND
        auto_en = 1'b0;
        frame_ack = 1'b0;
        sel = 2'd0;
        set_ch(0, 1'b1, 24'h876543);
        cyc(2);
        chk("pre_reset_valid", {31'd0, frame_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_frame", frame, 32'h0);
        chk("async_reset_valid", {31'd0, frame_valid}, 32'd0);
        cyc(2);
        rst_n = 1'b1;
        cyc(4);
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors so far %0d", n_errors);
        $fatal(1);
    end

endmodule

`default_nettype wire
